// File: rtl/ai_pkg.sv
// Shared definitions for the AI-unit arbiter: FSM state encoding and default timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ai_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // The WAIT timer is 8 bits wide, so the timeout cannot exceed 255.
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ai_unit_arbiter_rr_picker.sv
// Round-robin winner select: first asserted request at or after i_rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; o_vld low when no request is asserted.
// Ports: i_req (request vector), i_rr_ptr (search start index),
//        o_onehot (winner one-hot), o_idx (winner index), o_vld (any request).
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IW-1:0]    o_idx,
    output logic             o_vld
);

    int w_pos;

    // Walk offsets from farthest to nearest so the request closest to the
    // pointer is the last one written, i.e. it wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        w_pos    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_pos = (int'(i_rr_ptr) + i) % N_REQ;
            if (i_req[w_pos]) begin
                o_onehot        = '0;
                o_onehot[w_pos] = 1'b1;
                o_idx           = IW'(w_pos);
                o_vld           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ai_unit_arbiter.sv
// Shares one AI unit among N_REQ requesters: round-robin grant, start pulse, done/timeout handshake.
// Latency: req in IDLE -> grant 1 edge, unit_start 2 edges; unit_done -> req_done on the next edge.
// Backpressure: no grant while unit_busy is high; a stalled unit is aborted after TIMEOUT WAIT cycles.
// Ports: clk/rst (async active-high); req -> grant/owner_id; unit_start/unit_busy/unit_done to the
//        AI unit; req_done/req_err one-cycle completion pulses; arb_busy high outside IDLE.
module ai_unit_arbiter
    import ai_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] req_done,
    output logic [N_REQ-1:0] req_err,
    output logic             unit_start,
    input  logic             unit_busy,
    input  logic             unit_done,
    output logic [IW-1:0]    owner_id,
    output logic             arb_busy
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    arb_state_t       r_state, w_state_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [N_REQ-1:0] r_done, w_done_nxt;
    logic [N_REQ-1:0] r_err, w_err_nxt;
    logic             r_start, w_start_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [IW-1:0]    r_rr_ptr, w_rr_nxt;
    logic [7:0]       r_timer, w_timer_nxt;
    logic             r_arb_busy;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_vld;

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_vld    (w_pick_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_timer_nxt = r_timer;
        w_start_nxt = 1'b0;
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld && !unit_busy) begin
                    w_grant_nxt = w_pick_onehot;
                    w_owner_nxt = w_pick_idx;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_start_nxt = 1'b1;
                w_timer_nxt = '0;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is checked before the timeout so a done arriving
                // on the final allowed cycle is still reported as success.
                // The owner's req is deliberately not looked at here.
                if (unit_done) begin
                    w_done_nxt  = r_grant;
                    w_state_nxt = ST_RELEASE;
                end else if (r_timer == TIMEOUT_CNT) begin
                    w_err_nxt   = r_grant;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_timer_nxt = r_timer + 8'd1;
                end
            end
            ST_RELEASE: begin
                w_grant_nxt = '0;
                w_rr_nxt    = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_start    <= 1'b0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_timer    <= '0;
            r_arb_busy <= 1'b0;
        end else begin
            r_grant    <= w_grant_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_start    <= w_start_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_timer    <= w_timer_nxt;
            r_arb_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    assign grant      = r_grant;
    assign req_done   = r_done;
    assign req_err    = r_err;
    assign unit_start = r_start;
    assign owner_id   = r_owner;
    assign arb_busy   = r_arb_busy;

endmodule

// File: tb/tb_ai_unit_arbiter.sv
// Directed bench for ai_unit_arbiter: table of back-to-back transactions plus busy and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_ai_unit_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       unit_busy;
    logic       unit_done;
    logic [3:0] grant;
    logic [3:0] req_done;
    logic [3:0] req_err;
    logic       unit_start;
    logic [1:0] owner_id;
    logic       arb_busy;

    always #5 clk = ~clk;

    ai_unit_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .req_done   (req_done),
        .req_err    (req_err),
        .unit_start (unit_start),
        .unit_busy  (unit_busy),
        .unit_done  (unit_done),
        .owner_id   (owner_id),
        .arb_busy   (arb_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observations of one transaction, filled in by run_txn.
    logic [3:0] t_grant, t_done, t_err;
    logic [1:0] t_owner;
    int         t_nstart, t_start_cyc, t_pulse_cyc;
    logic       t_onehot_ok, t_busy_grant, t_busy_end, t_ok;

    // Follows one grant from the current (IDLE) point until grant clears.
    // unit_done is raised for one cycle dly cycles after unit_start is seen;
    // dly < 0 means the unit never completes.
    task automatic run_txn(input int dly);
        bit granted;
        granted      = 1'b0;
        t_grant      = '0;
        t_done       = '0;
        t_err        = '0;
        t_owner      = '0;
        t_nstart     = 0;
        t_start_cyc  = -1;
        t_pulse_cyc  = -1;
        t_onehot_ok  = 1'b1;
        t_busy_grant = 1'b0;
        t_busy_end   = 1'b1;
        t_ok         = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (!$onehot0(grant) || !$onehot0(req_done) || !$onehot0(req_err))
                t_onehot_ok = 1'b0;
            if (!granted && grant != 4'b0) begin
                granted      = 1'b1;
                t_grant      = grant;
                t_owner      = owner_id;
                t_busy_grant = arb_busy;
            end
            if (unit_start) begin
                t_nstart++;
                if (t_start_cyc < 0) t_start_cyc = cyc;
            end
            if (req_done != 4'b0 || req_err != 4'b0) begin
                t_done = t_done | req_done;
                t_err  = t_err | req_err;
                if (t_pulse_cyc < 0) t_pulse_cyc = cyc;
            end
            if (granted && grant == 4'b0) begin
                t_ok       = 1'b1;
                t_busy_end = arb_busy;
                break;
            end
            unit_done = (dly >= 0 && t_start_cyc > 0 && cyc == t_start_cyc + dly);
        end
        unit_done = 1'b0;
    endtask

    task automatic check_txn(input string tag, input logic [3:0] e_grant, input logic [1:0] e_owner,
                             input logic [3:0] e_done, input logic [3:0] e_err, input int e_pcyc);
        check({tag, " completed"},   32'(t_ok), 32'd1);
        check({tag, " grant"},       32'(t_grant), 32'(e_grant));
        check({tag, " owner_id"},    32'(t_owner), 32'(e_owner));
        check({tag, " req_done"},    32'(t_done), 32'(e_done));
        check({tag, " req_err"},     32'(t_err), 32'(e_err));
        check({tag, " start count"}, 32'(t_nstart), 32'd1);
        check({tag, " start cycle"}, 32'(t_start_cyc), 32'd2);
        check({tag, " pulse cycle"}, 32'(t_pulse_cyc), 32'(e_pcyc));
        check({tag, " onehot"},      32'(t_onehot_ok), 32'd1);
        check({tag, " busy in txn"}, 32'(t_busy_grant), 32'd1);
        check({tag, " busy after"},  32'(t_busy_end), 32'd0);
    endtask

    typedef struct {
        logic [3:0] req;
        int         dly;
        logic [3:0] exp_grant;
        logic [1:0] exp_owner;
        logic [3:0] exp_done;
        logic [3:0] exp_err;
        int         exp_pcyc;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Applied back to back from reset; round-robin pointer evolves row to row.
        // Pulse cycle: start is seen at cycle 2, so done appears at 3+dly; timeout at 2+TO+1 = 11.
        vecs[0]  = '{4'b1111,  1, 4'b0001, 2'd0, 4'b0001, 4'b0000,  4};
        vecs[1]  = '{4'b1111,  0, 4'b0010, 2'd1, 4'b0010, 4'b0000,  3};
        vecs[2]  = '{4'b1111,  3, 4'b0100, 2'd2, 4'b0100, 4'b0000,  6};
        vecs[3]  = '{4'b1111,  1, 4'b1000, 2'd3, 4'b1000, 4'b0000,  4};
        vecs[4]  = '{4'b1111,  2, 4'b0001, 2'd0, 4'b0001, 4'b0000,  5};
        vecs[5]  = '{4'b0001,  1, 4'b0001, 2'd0, 4'b0001, 4'b0000,  4};
        vecs[6]  = '{4'b0001,  1, 4'b0001, 2'd0, 4'b0001, 4'b0000,  4};
        vecs[7]  = '{4'b1001,  0, 4'b1000, 2'd3, 4'b1000, 4'b0000,  3};
        vecs[8]  = '{4'b1001,  0, 4'b0001, 2'd0, 4'b0001, 4'b0000,  3};
        vecs[9]  = '{4'b0100, -1, 4'b0100, 2'd2, 4'b0000, 4'b0100, 11};
        vecs[10] = '{4'b0110,  7, 4'b0010, 2'd1, 4'b0010, 4'b0000, 10};
        vecs[11] = '{4'b0110,  8, 4'b0100, 2'd2, 4'b0100, 4'b0000, 11};
        vecs[12] = '{4'b1010,  9, 4'b1000, 2'd3, 4'b0000, 4'b1000, 11};

        rst       = 1'b1;
        req       = '0;
        unit_busy = 1'b0;
        unit_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset grant",      32'(grant), 32'd0);
        check("reset req_done",   32'(req_done), 32'd0);
        check("reset req_err",    32'(req_err), 32'd0);
        check("reset unit_start", 32'(unit_start), 32'd0);
        check("reset owner_id",   32'(owner_id), 32'd0);
        check("reset arb_busy",   32'(arb_busy), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            req = vecs[i].req;
            run_txn(vecs[i].dly);
            check_txn($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_owner,
                      vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_pcyc);
        end

        // Unit busy blocks the grant; pointer is at 0 here.
        req       = 4'b0010;
        unit_busy = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge clk);
        check("busy hold grant",      32'(grant), 32'd0);
        check("busy hold arb_busy",   32'(arb_busy), 32'd0);
        check("busy hold unit_start", 32'(unit_start), 32'd0);
        unit_busy = 1'b0;
        run_txn(0);
        check_txn("after busy", 4'b0010, 2'd1, 4'b0010, 4'b0000, 3);

        // Reset in WAIT for owner 2: outputs clear at once, no pulses, pointer back to 0.
        req = 4'b0100;
        for (int c = 0; c < 3; c++) @(negedge clk);
        check("pre-reset grant", 32'(grant), 32'h4);
        rst = 1'b1;
        #1;
        check("async rst grant",      32'(grant), 32'd0);
        check("async rst unit_start", 32'(unit_start), 32'd0);
        check("async rst owner_id",   32'(owner_id), 32'd0);
        check("async rst arb_busy",   32'(arb_busy), 32'd0);
        @(negedge clk);
        check("rst req_done",  32'(req_done), 32'd0);
        check("rst req_err",   32'(req_err), 32'd0);
        req = 4'b0101;
        rst = 1'b0;
        run_txn(1);
        check_txn("post reset", 4'b0001, 2'd0, 4'b0001, 4'b0000, 4);

        req = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
